// File: rtl/fetch_sequencer.sv
// PC sequencer for the 2-wide fetch stage: start, stall re-read, redirect and halt-on-zero-word,
// plus per-slot valid qualification of the registered instruction pair.
module fetch_sequencer #(
  parameter logic [7:0]  RESET_PC    = 8'h00,
  parameter int          GROUP_BYTES = 8,
  parameter logic [31:0] HALT_WORD   = 32'h0000_0000,
  parameter int          CNT_W       = 16
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  input  logic             stall_i,
  input  logic             redirect_i,
  input  logic [7:0]       redirectPc_i,
  input  logic [31:0]      inst1In_i,
  input  logic [31:0]      inst2In_i,
  output logic [7:0]       fetchPc_o,
  output logic [7:0]       groupPc_o,
  output logic             inst1Valid_o,
  output logic             inst2Valid_o,
  output logic             halted_o,
  output logic [CNT_W-1:0] pairsFetched_o
);

  localparam logic [7:0] STEP = 8'(GROUP_BYTES);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [7:0]       groupPc_q, groupPc_d;
  logic [7:0]       nxtPc_q, nxtPc_d;
  logic             ovld_q, ovld_d;
  logic [CNT_W-1:0] pairs_q, pairs_d;

  logic             z1, z2, accept;
  logic [7:0]       redirTgt;
  logic [CNT_W-1:0] pairsInc;

  assign z1       = (inst1In_i == HALT_WORD);
  assign z2       = (inst2In_i == HALT_WORD);
  assign accept   = ovld_q & ~stall_i;
  assign redirTgt = {redirectPc_i[7:2], 2'b00};
  assign pairsInc = (pairs_q == {CNT_W{1'b1}}) ? pairs_q : pairs_q + CNT_W'(1);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      groupPc_q <= RESET_PC;
      nxtPc_q   <= RESET_PC + STEP;
      ovld_q    <= 1'b0;
      pairs_q   <= '0;
    end else begin
      state_q   <= state_d;
      groupPc_q <= groupPc_d;
      nxtPc_q   <= nxtPc_d;
      ovld_q    <= ovld_d;
      pairs_q   <= pairs_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start_i) state_d = RUN;
      RUN: begin
        if (redirect_i) state_d = RUN;
        else if (accept && (z1 || z2)) state_d = HALT;
      end
      HALT: if (redirect_i) state_d = RUN;
      default: state_d = IDLE;
    endcase
  end

  // Redirect beats stall and halt; a stalled pair is held by re-reading group_pc.
  always_comb begin
    groupPc_d = groupPc_q;
    nxtPc_d   = nxtPc_q;
    ovld_d    = ovld_q;
    pairs_d   = pairs_q;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          groupPc_d = RESET_PC;
          nxtPc_d   = RESET_PC + STEP;
          ovld_d    = 1'b1;
        end
      end
      RUN: begin
        if (redirect_i) begin
          groupPc_d = redirTgt;
          nxtPc_d   = redirTgt + STEP;
          ovld_d    = 1'b1;
        end else if (accept) begin
          pairs_d = pairsInc;
          if (z1 || z2) begin
            ovld_d = 1'b0;
          end else begin
            groupPc_d = nxtPc_q;
            nxtPc_d   = nxtPc_q + STEP;
            ovld_d    = 1'b1;
          end
        end
      end
      HALT: begin
        if (redirect_i) begin
          groupPc_d = redirTgt;
          nxtPc_d   = redirTgt + STEP;
          ovld_d    = 1'b1;
        end
      end
      default: begin
        ovld_d = 1'b0;
      end
    endcase
  end

  // A redirect out of HALT must also steer fetch so the target pair arrives without a bubble.
  always_comb begin
    fetchPc_o = RESET_PC;
    case (state_q)
      IDLE: fetchPc_o = RESET_PC;
      RUN: begin
        if (redirect_i) fetchPc_o = redirTgt;
        else if (ovld_q && stall_i) fetchPc_o = groupPc_q;
        else fetchPc_o = nxtPc_q;
      end
      HALT: fetchPc_o = redirect_i ? redirTgt : groupPc_q;
      default: fetchPc_o = RESET_PC;
    endcase
  end

  assign groupPc_o      = groupPc_q;
  assign inst1Valid_o   = ovld_q & ~z1;
  assign inst2Valid_o   = ovld_q & ~z1 & ~z2;
  assign halted_o       = (state_q == HALT);
  assign pairsFetched_o = pairs_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Random plus directed bench for fetch_sequencer: two instances (RESET_PC 00 / F8, narrow counter on
// the second) share stimulus and are compared every cycle against a pair-level reference model.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset, start, stall, redirect;
  logic [7:0]  redirectPc;
  logic [31:0] inst1A, inst2A, inst1B, inst2B;
  logic [7:0]  fetchPcA, fetchPcB, groupPcA, groupPcB;
  logic        v1A, v2A, v1B, v2B, haltA, haltB;
  logic [15:0] pairsA;
  logic [2:0]  pairsB;
  logic [31:0] mem [64];

  int checks = 0;
  int errors = 0;

  // Reference model: one entry per instance, tracked in terms of presented pairs.
  bit         mRun   [2];
  bit         mHalt  [2];
  bit         mOvld  [2];
  logic [7:0] mGroup [2];
  int         mCount [2];

  always #5 clk = ~clk;

  // Fetch stage: returns the 8 bytes at fetch_pc one clock later.
  always @(posedge clk) begin
    inst1A <= mem[fetchPcA[7:2]];
    inst2A <= mem[fetchPcA[7:2] + 6'd1];
    inst1B <= mem[fetchPcB[7:2]];
    inst2B <= mem[fetchPcB[7:2] + 6'd1];
  end

  fetch_sequencer #(.RESET_PC(8'h00), .GROUP_BYTES(8), .HALT_WORD(32'h0), .CNT_W(16)) dutA (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stall_i(stall), .redirect_i(redirect),
    .redirectPc_i(redirectPc), .inst1In_i(inst1A), .inst2In_i(inst2A),
    .fetchPc_o(fetchPcA), .groupPc_o(groupPcA), .inst1Valid_o(v1A), .inst2Valid_o(v2A),
    .halted_o(haltA), .pairsFetched_o(pairsA)
  );

  fetch_sequencer #(.RESET_PC(8'hF8), .GROUP_BYTES(8), .HALT_WORD(32'h0), .CNT_W(3)) dutB (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stall_i(stall), .redirect_i(redirect),
    .redirectPc_i(redirectPc), .inst1In_i(inst1B), .inst2In_i(inst2B),
    .fetchPc_o(fetchPcB), .groupPc_o(groupPcB), .inst1Valid_o(v1B), .inst2Valid_o(v2B),
    .halted_o(haltB), .pairsFetched_o(pairsB)
  );

  function automatic logic [31:0] memAt(input logic [7:0] addr);
    return mem[addr[7:2]];
  endfunction

  function automatic logic [7:0] resetPcOf(input int d);
    return (d == 0) ? 8'h00 : 8'hF8;
  endfunction

  function automatic int cntMax(input int d);
    return (d == 0) ? 65535 : 7;
  endfunction

  function automatic logic [7:0] expFetch(input int d);
    logic [7:0] tgt;
    tgt = redirectPc & 8'hFC;
    if (mHalt[d]) return redirect ? tgt : mGroup[d];
    if (!mRun[d]) return resetPcOf(d);
    if (redirect) return tgt;
    if (mOvld[d] && stall) return mGroup[d];
    return mGroup[d] + 8'd8;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic checkAll();
    logic e1, e2;
    for (int d = 0; d < 2; d++) begin
      e1 = mOvld[d] && (memAt(mGroup[d]) != 32'h0);
      e2 = e1 && (memAt(mGroup[d] + 8'd4) != 32'h0);
      checkOutput($sformatf("fetchPc[%0d]", d), {24'h0, (d == 0) ? fetchPcA : fetchPcB},
                  {24'h0, expFetch(d)});
      checkOutput($sformatf("groupPc[%0d]", d), {24'h0, (d == 0) ? groupPcA : groupPcB},
                  {24'h0, mGroup[d]});
      checkOutput($sformatf("inst1Valid[%0d]", d), {31'h0, (d == 0) ? v1A : v1B}, {31'h0, e1});
      checkOutput($sformatf("inst2Valid[%0d]", d), {31'h0, (d == 0) ? v2A : v2B}, {31'h0, e2});
      checkOutput($sformatf("halted[%0d]", d), {31'h0, (d == 0) ? haltA : haltB},
                  {31'h0, mHalt[d]});
      checkOutput($sformatf("pairsFetched[%0d]", d),
                  (d == 0) ? {16'h0, pairsA} : {29'h0, pairsB}, mCount[d]);
    end
  endtask

  task automatic modelStep();
    logic [7:0] tgt;
    bit z;
    tgt = redirectPc & 8'hFC;
    for (int d = 0; d < 2; d++) begin
      z = (memAt(mGroup[d]) == 32'h0) || (memAt(mGroup[d] + 8'd4) == 32'h0);
      if (reset) begin
        mRun[d] = 0; mHalt[d] = 0; mOvld[d] = 0; mGroup[d] = resetPcOf(d); mCount[d] = 0;
      end else if (mHalt[d]) begin
        if (redirect) begin
          mHalt[d] = 0; mRun[d] = 1; mOvld[d] = 1; mGroup[d] = tgt;
        end
      end else if (!mRun[d]) begin
        if (start) begin
          mRun[d] = 1; mOvld[d] = 1; mGroup[d] = resetPcOf(d);
        end
      end else if (redirect) begin
        mGroup[d] = tgt; mOvld[d] = 1;
      end else if (!stall) begin
        if (mCount[d] < cntMax(d)) mCount[d]++;
        if (z) begin
          mRun[d] = 0; mHalt[d] = 1; mOvld[d] = 0;
        end else begin
          mGroup[d] = mGroup[d] + 8'd8;
        end
      end
    end
  endtask

  // Hold the given inputs for n cycles, checking every cycle before the edge.
  task automatic applyStimulus(input logic rst, input logic st, input logic stl, input logic rd,
                               input logic [7:0] rpc, input int n);
    for (int i = 0; i < n; i++) begin
      reset = rst; start = st; stall = stl; redirect = rd; redirectPc = rpc;
      #1;
      checkAll();
      modelStep();
      @(posedge clk);
      @(negedge clk);
    end
  endtask

  task automatic fillRandomMem();
    for (int i = 0; i < 64; i++) mem[i] = ($urandom_range(0, 11) == 0) ? 32'h0 : ($urandom | 32'h1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
    mem[3] = 32'h0;
    reset = 1'b1; start = 1'b0; stall = 1'b0; redirect = 1'b0; redirectPc = 8'h00;
    for (int d = 0; d < 2; d++) begin
      mRun[d] = 0; mHalt[d] = 0; mOvld[d] = 0; mGroup[d] = resetPcOf(d); mCount[d] = 0;
    end
    @(posedge clk);
    @(negedge clk);

    applyStimulus(1, 0, 0, 0, 8'h00, 2);
    applyStimulus(0, 0, 0, 0, 8'h00, 2);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 4);
    applyStimulus(0, 1, 1, 0, 8'h00, 2);
    applyStimulus(0, 0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 1, 8'h20, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 1, 0, 8'h00, 3);
    applyStimulus(0, 0, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 1, 1, 8'h43, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 2);
    applyStimulus(1, 0, 1, 0, 8'h00, 1);
    applyStimulus(0, 0, 1, 0, 8'h00, 1);
    applyStimulus(0, 1, 0, 0, 8'h00, 1);
    applyStimulus(0, 0, 0, 0, 8'h00, 3);

    for (int epoch = 0; epoch < 30; epoch++) begin
      applyStimulus(1, 0, 0, 0, 8'h00, 1);
      fillRandomMem();
      applyStimulus(0, 1, 0, 0, 8'h00, 1);
      for (int c = 0; c < 50; c++) begin
        applyStimulus(($urandom_range(0, 63) == 0), ($urandom_range(0, 3) == 0),
                      ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                      8'($urandom), 1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
